jtopl_am_sched: RTL and testbench

- Slot sequencer and tremolo (AM) LFO generator that drives the envelope final-attenuation stage.
- Steps through the 18 operator slots and supplies each slot's amsen bit, aligned with the slot index.
- Produces the 7-bit lfo_mod phase and the frame-latched global ams depth bit. All slots in one frame see identical lfo_mod/ams values.
- Sits between the register file (amsen vector, depth bit, test bit) and the EG final-attenuation datapath.

---
 rtl/jtopl_pkg.sv | 7 +
 rtl/jtopl_am_lfo.sv | 46 ++++
 rtl/jtopl_am_sched.sv | 75 +++++++
 tb/tb_jtopl_am_sched.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL slot sequencer and tremolo LFO.
package jtopl_pkg;
    localparam int JTOPL_NUM_SLOTS = 18;
    localparam int JTOPL_AM_DIV    = 104;
    localparam int JTOPL_LFO_W     = 7;
    localparam int JTOPL_SLOT_W    = 5;
endpackage

// File: rtl/jtopl_am_lfo.sv
// Tremolo phase generator: frame divider plus 7-bit triangle phase counter.
module jtopl_am_lfo
    import jtopl_pkg::*;
#(
    parameter int AM_DIV = JTOPL_AM_DIV,
    parameter int DIV_W  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_end,
    input  logic                   am_hold,
    output logic [JTOPL_LFO_W-1:0] lfo_mod
);
    logic [DIV_W-1:0]       div_q, div_d;
    logic [JTOPL_LFO_W-1:0] lfo_q, lfo_d;

    // NOTE: every next-state signal gets a hold default first, so no path leaves it unassigned (no latch).
    always_comb begin
        div_d = div_q;
        lfo_d = lfo_q;
        if (frame_end) begin
            if (am_hold) begin
                div_d = '0;
                lfo_d = '0;
            end else if (div_q == DIV_W'(AM_DIV - 1)) begin
                div_d = '0;
                lfo_d = lfo_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; all decisions live in the always_comb above.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            lfo_q <= '0;
        end else begin
            div_q <= div_d;
            lfo_q <= lfo_d;
        end
    end

    assign lfo_mod = lfo_q;
endmodule

// File: rtl/jtopl_am_sched.sv
// Slot sequencer with per-slot AM enable, frame-latched depth bit and tremolo LFO.
module jtopl_am_sched
    import jtopl_pkg::*;
#(
    parameter int NUM_SLOTS = JTOPL_NUM_SLOTS,
    parameter int AM_DIV    = JTOPL_AM_DIV,
    parameter int DIV_W     = 7
) (
    input  logic                    rst,
    input  logic                    clk,
    input  logic                    cen,
    input  logic                    am_hold,
    input  logic                    ams_in,
    input  logic [NUM_SLOTS-1:0]    amsen_vec,
    output logic [JTOPL_SLOT_W-1:0] slot,
    output logic                    zero,
    output logic [JTOPL_LFO_W-1:0]  lfo_mod,
    output logic                    ams,
    output logic                    amsen
);
    logic [JTOPL_SLOT_W-1:0] slot_q, slot_d, next_slot;
    logic                    zero_q, zero_d;
    logic                    ams_q, ams_d;
    logic                    amsen_q, amsen_d;
    logic                    frame_end;

    assign frame_end = cen && (slot_q == JTOPL_SLOT_W'(NUM_SLOTS - 1));
    assign next_slot = frame_end ? '0 : slot_q + 1'b1;

    // amsen is fetched for the slot about to be shown, keeping it aligned with slot.
    always_comb begin
        slot_d  = slot_q;
        zero_d  = zero_q;
        ams_d   = ams_q;
        amsen_d = amsen_q;
        if (cen) begin
            slot_d  = next_slot;
            zero_d  = (next_slot == '0);
            amsen_d = amsen_vec[next_slot];
        end
        if (frame_end) begin
            ams_d = ams_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q  <= '0;
            zero_q  <= 1'b1;
            ams_q   <= 1'b0;
            amsen_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            zero_q  <= zero_d;
            ams_q   <= ams_d;
            amsen_q <= amsen_d;
        end
    end

    jtopl_am_lfo #(
        .AM_DIV (AM_DIV),
        .DIV_W  (DIV_W)
    ) u_lfo (
        .clk       (clk),
        .rst       (rst),
        .frame_end (frame_end),
        .am_hold   (am_hold),
        .lfo_mod   (lfo_mod)
    );

    assign slot  = slot_q;
    assign zero  = zero_q;
    assign ams   = ams_q;
    assign amsen = amsen_q;
endmodule

// File: tb/tb_jtopl_am_sched.sv
// Directed bench for jtopl_am_sched with a shortened LFO divider (AM_DIV=4).
module tb_jtopl_am_sched;
    localparam int NS  = 18;
    localparam int DIV = 4;

    logic          rst, clk, cen, am_hold, ams_in;
    logic [NS-1:0] amsen_vec;
    logic [4:0]    slot;
    logic          zero, ams, amsen;
    logic [6:0]    lfo_mod;

    int checks   = 0;
    int failures = 0;
    int frames   = 0;

    jtopl_am_sched #(.NUM_SLOTS(NS), .AM_DIV(DIV), .DIV_W(7)) dut (
        .rst       (rst),
        .clk       (clk),
        .cen       (cen),
        .am_hold   (am_hold),
        .ams_in    (ams_in),
        .amsen_vec (amsen_vec),
        .slot      (slot),
        .zero      (zero),
        .lfo_mod   (lfo_mod),
        .ams       (ams),
        .amsen     (amsen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_slot"}, 32'(slot), 0);
        check({tag, "_zero"}, 32'(zero), 1);
        check({tag, "_lfo"}, 32'(lfo_mod), 0);
        check({tag, "_ams"}, 32'(ams), 0);
        check({tag, "_amsen"}, 32'(amsen), 0);
    endtask

    // Run whole frames with cen held high, starting and ending at slot 0.
    task automatic run_frames_to(input int target);
        cen = 1'b1;
        while (frames < target) begin
            for (int i = 0; i < NS; i++) tick();
            frames++;
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; ams_in = 1'b1; am_hold = 1'b0; amsen_vec = '0;
        #2;
        tick(); tick();
        check_reset_values("reset");

        rst = 1'b0; cen = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_reset_values("cen_hold");

        // Frame 1: slot walk, zero flag, amsen on slot 3 only.
        ams_in = 1'b0;
        amsen_vec = 18'h00008;
        cen = 1'b1;
        for (int k = 1; k <= NS; k++) begin
            tick();
            check("walk_slot", 32'(slot), k % NS);
            check("walk_zero", 32'(zero), 32'(k == NS));
            check("walk_amsen", 32'(amsen), 32'(k == 3));
        end
        frames = 1;

        // Frame 2: bit 17 set while at slot 10 shows up at slot 17 of the same frame.
        for (int k = 1; k <= NS; k++) begin
            tick();
            check("late_amsen", 32'(amsen), 32'(k == 3 || k == 17));
            if (k == 10) amsen_vec[17] = 1'b1;
        end
        frames = 2;

        run_frames_to(3);
        check("lfo_f3", 32'(lfo_mod), 0);
        run_frames_to(4);
        check("lfo_f4", 32'(lfo_mod), 1);
        run_frames_to(256);
        check("lfo_f256", 32'(lfo_mod), 64);
        run_frames_to(508);
        check("lfo_f508", 32'(lfo_mod), 127);
        run_frames_to(511);
        check("lfo_f511", 32'(lfo_mod), 127);
        run_frames_to(512);
        check("lfo_wrap", 32'(lfo_mod), 0);

        // ams_in rises at slot 5: ams only follows at the frame boundary.
        for (int k = 1; k <= NS; k++) begin
            tick();
            if (k == 5) ams_in = 1'b1;
            check("ams_late", 32'(ams), 32'(k == NS));
        end
        frames++;
        ams_in = 1'b0;
        run_frames_to(frames + 1);
        check("ams_low", 32'(ams), 0);

        // Mid-frame pulse of ams_in must never reach ams.
        for (int k = 1; k <= NS; k++) begin
            tick();
            ams_in = (k >= 2 && k < 7);
            check("ams_pulse", 32'(ams), 0);
        end
        frames++;

        run_frames_to(512 + 37 * DIV);
        check("lfo_37", 32'(lfo_mod), 37);
        check("lfo_37_slot", 32'(slot), 0);

        am_hold = 1'b1;
        run_frames_to(frames + 1);
        check("hold_clear", 32'(lfo_mod), 0);
        am_hold = 1'b0;
        run_frames_to(frames + DIV - 1);
        check("hold_release_early", 32'(lfo_mod), 0);
        run_frames_to(frames + 1);
        check("hold_release_step", 32'(lfo_mod), 1);

        // Reset at slot 9 with ams set and lfo nonzero.
        ams_in = 1'b1;
        run_frames_to(frames + 1);
        check("pre_rst_ams", 32'(ams), 1);
        for (int k = 0; k < 9; k++) tick();
        check("pre_rst_slot", 32'(slot), 9);
        rst = 1'b1;
        tick();
        check_reset_values("mid_rst");
        rst = 1'b0;
        tick();
        check("post_rst_slot", 32'(slot), 1);
        check("post_rst_zero", 32'(zero), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
